nibble_add_arb: RTL and testbench

NIBBLE_ADD_ARB -- requirements
Module: nibble_add_arb

---
 rtl/nibble_add_arb.sv | 116 +++++++++++
 tb/tb_nibble_add_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_arb.sv
// Two-requester round-robin arbiter in front of a nibble-serial adder.
// One 4-bit adder with carry-in is reused over NIB cycles per operation.
module nibble_add_arb #(
  parameter int unsigned NIB = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [4*NIB-1:0]     req0_a,
  input  logic [4*NIB-1:0]     req0_b,
  input  logic [4*NIB-1:0]     req1_a,
  input  logic [4*NIB-1:0]     req1_b,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic                 rsp_valid,
  output logic [4*NIB-1:0]     rsp_sum,
  output logic                 rsp_carry,
  output logic                 rsp_id,
  input  logic                 rsp_ready,
  output logic                 busy
);

  localparam int unsigned W  = 4 * NIB;
  localparam int unsigned CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            ptr;       // last requester granted
  logic            carry;     // nibble carry between CALC cycles
  logic [CW-1:0]   cnt;       // nibble index within CALC
  logic [W-1:0]    a_q;       // operands, shifted down one nibble per cycle
  logic [W-1:0]    b_q;
  logic [4:0]      nib_sum;
  logic            grant0;
  logic            grant1;

  // Round-robin grant, only offered in IDLE and never during reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (req0_valid && (!req1_valid || ptr)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);

  // The single shared 4-bit adder with carry-in
  always_comb begin
    nib_sum = 5'({1'b0, a_q[3:0]}) + 5'({1'b0, b_q[3:0]}) + 5'({4'b0000, carry});
  end

  // Control FSM, operand capture and nibble-serial result accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b1;
      carry     <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            a_q       <= grant1 ? req1_a : req0_a;
            b_q       <= grant1 ? req1_b : req0_b;
            rsp_id    <= grant1;
            ptr       <= grant1;
            carry     <= 1'b0;
            cnt       <= '0;
            rsp_sum   <= '0;
            rsp_carry <= 1'b0;
            state     <= CALC;
          end
        end
        CALC: begin
          rsp_sum[{cnt, 2'b00} +: 4] <= nib_sum[3:0];
          carry <= nib_sum[4];
          a_q   <= a_q >> 4;
          b_q   <= b_q >> 4;
          if (cnt == CW'(NIB - 1)) begin
            rsp_carry <= nib_sum[4];
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_arb.sv
// Directed bench for nibble_add_arb: NIB=2 main instance plus NIB=1/NIB=4 sweep instances.
module tb_nibble_add_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // NIB=2 instance
  logic       r0v, r1v, r0rdy, r1rdy, rv, rc, rid, rr, bsy;
  logic [7:0] r0a, r0b, r1a, r1b, rs;

  nibble_add_arb #(.NIB(2)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(r0v), .req1_valid(r1v),
    .req0_a(r0a), .req0_b(r0b), .req1_a(r1a), .req1_b(r1b),
    .req0_ready(r0rdy), .req1_ready(r1rdy),
    .rsp_valid(rv), .rsp_sum(rs), .rsp_carry(rc), .rsp_id(rid),
    .rsp_ready(rr), .busy(bsy)
  );

  // NIB=1 instance
  logic       s1_v, s1_rdy, s1_r1rdy, s1_rv, s1_c, s1_id, s1_busy;
  logic [3:0] s1_a, s1_b, s1_s;
  logic [3:0] z4 = 4'h0;
  logic       zv = 1'b0;
  logic       one = 1'b1;

  nibble_add_arb #(.NIB(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(s1_v), .req1_valid(zv),
    .req0_a(s1_a), .req0_b(s1_b), .req1_a(z4), .req1_b(z4),
    .req0_ready(s1_rdy), .req1_ready(s1_r1rdy),
    .rsp_valid(s1_rv), .rsp_sum(s1_s), .rsp_carry(s1_c), .rsp_id(s1_id),
    .rsp_ready(one), .busy(s1_busy)
  );

  // NIB=4 instance
  logic        s4_v, s4_rdy, s4_r1rdy, s4_rv, s4_c, s4_id, s4_busy;
  logic [15:0] s4_a, s4_b, s4_s;
  logic [15:0] z16 = 16'h0;

  nibble_add_arb #(.NIB(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(s4_v), .req1_valid(zv),
    .req0_a(s4_a), .req0_b(s4_b), .req1_a(z16), .req1_b(z16),
    .req0_ready(s4_rdy), .req1_ready(s4_r1rdy),
    .rsp_valid(s4_rv), .rsp_sum(s4_s), .rsp_carry(s4_c), .rsp_id(s4_id),
    .rsp_ready(one), .busy(s4_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single req0 operation on the NIB=2 instance with rsp_ready high
  task automatic op0(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] es, input logic ec);
    int n;
    r0a = a; r0b = b; r0v = 1'b1;
    #1;
    chk("op0_ready", 32'(r0rdy), 32'd1);
    tick();
    r0v = 1'b0;
    n = 1;
    while (!rv && n < 10) begin
      tick();
      n++;
    end
    chk("op0_latency", 32'(n), 32'd3);
    chk("op0_sum", 32'(rs), 32'(es));
    chk("op0_carry", 32'(rc), 32'(ec));
    chk("op0_id", 32'(rid), 32'd0);
    tick();
    chk("op0_idle", 32'(bsy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [16:0] e16;
    logic [4:0]  e4;

    reset = 1'b1;
    r0v = 1'b1; r1v = 1'b1; rr = 1'b0;
    r0a = '0; r0b = '0; r1a = '0; r1b = '0;
    s1_v = 1'b0; s1_a = '0; s1_b = '0;
    s4_v = 1'b0; s4_a = '0; s4_b = '0;
    tick();
    tick();

    // Reset state, readies suppressed while reset is high
    chk("rst_ready0", 32'(r0rdy), 32'd0);
    chk("rst_ready1", 32'(r1rdy), 32'd0);
    chk("rst_valid", 32'(rv), 32'd0);
    chk("rst_sum", 32'(rs), 32'd0);
    chk("rst_carry", 32'(rc), 32'd0);
    chk("rst_id", 32'(rid), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);

    // Single request: 0x3C + 0x15 = 0x51
    r1v = 1'b0; r0a = 8'h3C; r0b = 8'h15; rr = 1'b1;
    reset = 1'b0;
    #1;
    chk("single_ready0", 32'(r0rdy), 32'd1);
    chk("single_ready1", 32'(r1rdy), 32'd0);
    tick();
    r0v = 1'b0;
    chk("single_busy", 32'(bsy), 32'd1);
    chk("single_cleared_sum", 32'(rs), 32'd0);
    tick();
    chk("single_partial_sum", 32'(rs), 32'h01);
    chk("single_not_valid", 32'(rv), 32'd0);
    tick();
    chk("single_valid", 32'(rv), 32'd1);
    chk("single_sum", 32'(rs), 32'h51);
    chk("single_carry", 32'(rc), 32'd0);
    chk("single_id", 32'(rid), 32'd0);
    tick();
    chk("single_back_idle_valid", 32'(rv), 32'd0);
    chk("single_back_idle_busy", 32'(bsy), 32'd0);

    // Wrap and nibble carry propagation
    op0(8'hFF, 8'h01, 8'h00, 1'b1);
    op0(8'h0F, 8'h01, 8'h10, 1'b0);

    // Tie arbitration after reset: grants 0,1,0,1 every 4 cycles
    reset = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    r0a = 8'h12; r0b = 8'h34; r1a = 8'hA0; r1b = 8'h70;
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("tie_ready0", 32'(r0rdy), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("tie_ready1", 32'(r1rdy), (i % 2 == 1) ? 32'd1 : 32'd0);
      tick();
      tick();
      tick();
      chk("tie_valid", 32'(rv), 32'd1);
      chk("tie_id", 32'(rid), 32'(i % 2));
      chk("tie_sum", 32'(rs), (i % 2 == 0) ? 32'h46 : 32'h10);
      chk("tie_carry", 32'(rc), (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
    end
    r0v = 1'b0; r1v = 1'b0;

    // Backpressure: 5 cycles of rsp_ready low in RESP with req1 pending
    rr = 1'b0;
    r0a = 8'h21; r0b = 8'h43; r0v = 1'b1;
    #1;
    chk("bp_ready0", 32'(r0rdy), 32'd1);
    tick();
    r0v = 1'b0;
    tick();
    tick();
    r1v = 1'b1; r1a = 8'h05; r1b = 8'h06;
    #1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", 32'(rv), 32'd1);
      chk("bp_sum", 32'(rs), 32'h64);
      chk("bp_busy", 32'(bsy), 32'd1);
      chk("bp_no_grant", 32'(r1rdy), 32'd0);
      if (j < 4) tick();
    end
    rr = 1'b1;
    tick();
    chk("bp_idle_busy", 32'(bsy), 32'd0);
    chk("bp_idle_valid", 32'(rv), 32'd0);
    chk("bp_pending_grant", 32'(r1rdy), 32'd1);
    tick();
    r1v = 1'b0;
    tick();
    tick();
    chk("bp_req1_valid", 32'(rv), 32'd1);
    chk("bp_req1_id", 32'(rid), 32'd1);
    chk("bp_req1_sum", 32'(rs), 32'h0B);
    tick();

    // Reset mid-CALC after first nibble
    r0a = 8'h3C; r0b = 8'h15; r0v = 1'b1;
    #1;
    tick();
    r0v = 1'b0;
    tick();
    chk("midrst_partial", 32'(rs), 32'h01);
    reset = 1'b1;
    r0v = 1'b1; r1v = 1'b1;
    r0a = 8'h44; r0b = 8'h11; r1a = 8'h99; r1b = 8'h99;
    tick();
    chk("midrst_valid", 32'(rv), 32'd0);
    chk("midrst_sum", 32'(rs), 32'd0);
    chk("midrst_carry", 32'(rc), 32'd0);
    chk("midrst_id", 32'(rid), 32'd0);
    chk("midrst_busy", 32'(bsy), 32'd0);
    chk("midrst_ready0", 32'(r0rdy), 32'd0);
    chk("midrst_ready1", 32'(r1rdy), 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_tie_ready0", 32'(r0rdy), 32'd1);
    chk("midrst_tie_ready1", 32'(r1rdy), 32'd0);
    tick();
    r0v = 1'b0; r1v = 1'b0;
    tick();
    chk("midrst_no_stale_rsp", 32'(rv), 32'd0);
    tick();
    chk("midrst_new_valid", 32'(rv), 32'd1);
    chk("midrst_new_sum", 32'(rs), 32'h55);
    chk("midrst_new_id", 32'(rid), 32'd0);
    tick();

    // NIB=1 sweep
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        s1_a = 4'hF; s1_b = 4'h1;
      end else begin
        s1_a = 4'($urandom); s1_b = 4'($urandom);
      end
      e4 = {1'b0, s1_a} + {1'b0, s1_b};
      s1_v = 1'b1;
      #1;
      chk("n1_ready", 32'(s1_rdy), 32'd1);
      tick();
      s1_v = 1'b0;
      n = 1;
      while (!s1_rv && n < 12) begin
        tick();
        n++;
      end
      chk("n1_latency", 32'(n), 32'd2);
      chk("n1_sum", 32'(s1_s), 32'(e4[3:0]));
      chk("n1_carry", 32'(s1_c), 32'(e4[4]));
      tick();
    end

    // NIB=4 sweep
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        s4_a = 16'hFFFF; s4_b = 16'h0001;
      end else begin
        s4_a = 16'($urandom); s4_b = 16'($urandom);
      end
      e16 = {1'b0, s4_a} + {1'b0, s4_b};
      s4_v = 1'b1;
      #1;
      chk("n4_ready", 32'(s4_rdy), 32'd1);
      tick();
      s4_v = 1'b0;
      n = 1;
      while (!s4_rv && n < 12) begin
        tick();
        n++;
      end
      chk("n4_latency", 32'(n), 32'd5);
      chk("n4_sum", 32'(s4_s), 32'(e16[15:0]));
      chk("n4_carry", 32'(s4_c), 32'(e16[16]));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
